// File: rtl/dmem_pkg.sv
// Shared types and constants for the data-memory bus controller.
// State encoding, error-flag bit positions and the default error word.
package dmem_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      DONE = 2'd2
   } state_e;

   localparam int ERR_MISALIGN = 0;
   localparam int ERR_TIMEOUT  = 1;

   localparam logic [31:0] ERR_DATA_DEFAULT = 32'hDEADBEEF;

endpackage

// File: rtl/dmem_bus_ctrl_timeout.sv
// Wait-cycle counter for an outstanding bus transaction.
// expired is high in the BUSY cycle that would make the count reach TIMEOUT.
module bus_timeout_ctr #(
   parameter int TIMEOUT = 255
) (
   input  logic clk,
   input  logic reset,
   input  logic clr,
   input  logic en,
   output logic expired
);

   localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
   localparam logic [CW-1:0] LAST = CW'(TIMEOUT - 1);

   logic [CW-1:0] count_q;
   logic [CW-1:0] count_d;

   // expiry is only meaningful while counting
   always_comb begin
      expired = en && (count_q == LAST);
   end

   // clear has priority; expiry restarts the count so it never wraps
   always_comb begin
      count_d = count_q;
      if (clr || expired) begin
         count_d = '0;
      end else if (en) begin
         count_d = count_q + 1'b1;
      end
   end

   // count register
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

endmodule

// File: rtl/dmem_bus_ctrl.sv
// Data-memory access controller: turns a datapath load/store into a
// req/ack bus transaction and stalls the core until it completes.
module dmem_bus_ctrl
   import dmem_pkg::*;
#(
   parameter int              AW       = 32,
   parameter int              DW       = 32,
   parameter int              TIMEOUT  = 255,
   parameter logic [DW-1:0]   ERR_DATA = ERR_DATA_DEFAULT
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          memread,
   input  logic          memwrite,
   input  logic [AW-1:0] aluout,
   input  logic [DW-1:0] writedata,
   output logic [DW-1:0] readdata,
   output logic          stall,
   output logic          bus_req,
   output logic          bus_we,
   output logic [AW-1:0] bus_addr,
   output logic [DW-1:0] bus_wdata,
   input  logic          bus_ack,
   input  logic [DW-1:0] bus_rdata,
   output logic [1:0]    err,
   input  logic          err_clr
);

   state_e        state_q;
   state_e        state_d;
   logic [DW-1:0] readdata_q;
   logic [DW-1:0] readdata_d;
   logic          bus_req_q;
   logic          bus_req_d;
   logic          bus_we_q;
   logic          bus_we_d;
   logic [AW-1:0] bus_addr_q;
   logic [AW-1:0] bus_addr_d;
   logic [DW-1:0] bus_wdata_q;
   logic [DW-1:0] bus_wdata_d;
   logic [1:0]    err_q;
   logic [1:0]    err_d;
   logic          stall_c;

   logic access;
   logic aligned;
   logic ctr_en;
   logic ctr_clr;
   logic expired;

   assign access  = memread | memwrite;
   assign aligned = (aluout[1:0] == 2'b00);
   assign ctr_en  = (state_q == BUSY);
   assign ctr_clr = (state_q != BUSY) | bus_ack;

   bus_timeout_ctr #(
      .TIMEOUT(TIMEOUT)
   ) u_ctr (
      .clk    (clk),
      .reset  (reset),
      .clr    (ctr_clr),
      .en     (ctr_en),
      .expired(expired)
   );

   // state register
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // next state: ack wins over a timeout landing in the same cycle
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE: if (access && aligned) state_d = BUSY;
         BUSY: if (bus_ack || expired) state_d = DONE;
         DONE: state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // outputs and datapath register updates
   always_comb begin
      stall_c     = 1'b0;
      readdata_d  = readdata_q;
      bus_req_d   = bus_req_q;
      bus_we_d    = bus_we_q;
      bus_addr_d  = bus_addr_q;
      bus_wdata_d = bus_wdata_q;
      err_d       = err_clr ? 2'b00 : err_q;
      unique case (state_q)
         IDLE: begin
            if (access) begin
               if (aligned) begin
                  stall_c     = 1'b1;
                  bus_req_d   = 1'b1;
                  bus_we_d    = memwrite;
                  bus_addr_d  = aluout;
                  bus_wdata_d = writedata;
               end else begin
                  err_d[ERR_MISALIGN] = 1'b1;
                  readdata_d          = '0;
               end
            end
         end
         BUSY: begin
            stall_c = 1'b1;
            if (bus_ack) begin
               bus_req_d = 1'b0;
               if (!bus_we_q) readdata_d = bus_rdata;
            end else if (expired) begin
               bus_req_d          = 1'b0;
               err_d[ERR_TIMEOUT] = 1'b1;
               if (!bus_we_q) readdata_d = ERR_DATA;
            end
         end
         DONE: ;
         default: ;
      endcase
   end

   // datapath registers
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         readdata_q  <= '0;
         bus_req_q   <= 1'b0;
         bus_we_q    <= 1'b0;
         bus_addr_q  <= '0;
         bus_wdata_q <= '0;
         err_q       <= 2'b00;
      end else begin
         readdata_q  <= readdata_d;
         bus_req_q   <= bus_req_d;
         bus_we_q    <= bus_we_d;
         bus_addr_q  <= bus_addr_d;
         bus_wdata_q <= bus_wdata_d;
         err_q       <= err_d;
      end
   end

   // stall falls with reset so a held load cannot freeze the core
   assign stall     = stall_c & ~reset;
   assign readdata  = readdata_q;
   assign bus_req   = bus_req_q;
   assign bus_we    = bus_we_q;
   assign bus_addr  = bus_addr_q;
   assign bus_wdata = bus_wdata_q;
   assign err       = err_q;

endmodule

// File: tb/tb_dmem_bus_ctrl.sv
// Bench for dmem_bus_ctrl: directed scenarios plus random loads/stores,
// checked against a transaction-level expectation of each access.
module tb_dmem_bus_ctrl;

   localparam int TO = 4;

   logic        clk;
   logic        reset;
   logic        memread;
   logic        memwrite;
   logic [31:0] aluout;
   logic [31:0] writedata;
   logic [31:0] readdata;
   logic        stall;
   logic        bus_req;
   logic        bus_we;
   logic [31:0] bus_addr;
   logic [31:0] bus_wdata;
   logic        bus_ack;
   logic [31:0] bus_rdata;
   logic [1:0]  err;
   logic        err_clr;

   int n_chk = 0;
   int n_err = 0;
   int n_req = 0;

   logic [31:0] m_rd;
   logic [1:0]  m_err;

   dmem_bus_ctrl #(
      .AW(32),
      .DW(32),
      .TIMEOUT(TO),
      .ERR_DATA(32'hDEADBEEF)
   ) dut (
      .clk      (clk),
      .reset    (reset),
      .memread  (memread),
      .memwrite (memwrite),
      .aluout   (aluout),
      .writedata(writedata),
      .readdata (readdata),
      .stall    (stall),
      .bus_req  (bus_req),
      .bus_we   (bus_we),
      .bus_addr (bus_addr),
      .bus_wdata(bus_wdata),
      .bus_ack  (bus_ack),
      .bus_rdata(bus_rdata),
      .err      (err),
      .err_clr  (err_clr)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // counts bus transactions as seen on the wire
   always @(posedge bus_req) n_req++;

   task automatic check_eq(input string tag,
                           input logic [31:0] got,
                           input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic idle_cyc(input bit ack, input bit clr);
      @(negedge clk);
      memread   = 1'b0;
      memwrite  = 1'b0;
      aluout    = $urandom;
      writedata = $urandom;
      bus_ack   = ack;
      bus_rdata = $urandom;
      err_clr   = clr;
      #1;
      check_eq("idle_stall", 32'(stall), 32'd0);
      check_eq("idle_req", 32'(bus_req), 32'd0);
      check_eq("idle_rd", readdata, m_rd);
      check_eq("idle_err", 32'(err), 32'(m_err));
      if (clr) m_err = 2'b00;
   endtask

   task automatic mis_acc(input bit wr, input logic [31:0] addr,
                          input bit clr);
      @(negedge clk);
      memread   = !wr;
      memwrite  = wr;
      aluout    = addr;
      writedata = $urandom;
      bus_ack   = 1'b0;
      err_clr   = clr;
      #1;
      check_eq("mis_stall", 32'(stall), 32'd0);
      m_err = clr ? 2'b01 : (m_err | 2'b01);
      m_rd  = 32'd0;
      @(negedge clk);
      memread  = 1'b0;
      memwrite = 1'b0;
      err_clr  = 1'b0;
      #1;
      check_eq("mis_req", 32'(bus_req), 32'd0);
      check_eq("mis_err", 32'(err), 32'(m_err));
      check_eq("mis_rd", readdata, m_rd);
   endtask

   // dly = BUSY cycles before the ack cycle; dly >= TO means no ack
   task automatic acc(input bit rd, input bit wr,
                      input logic [31:0] addr, input logic [31:0] wdata,
                      input logic [31:0] rdata, input int dly);
      bit hit;
      int nb;
      hit = (dly < TO);
      nb  = hit ? dly + 1 : TO;
      @(negedge clk);
      memread   = rd;
      memwrite  = wr;
      aluout    = addr;
      writedata = wdata;
      bus_ack   = 1'b0;
      bus_rdata = $urandom;
      err_clr   = 1'b0;
      #1;
      check_eq("acc_stall0", 32'(stall), 32'd1);
      check_eq("acc_req0", 32'(bus_req), 32'd0);
      for (int k = 1; k <= nb; k++) begin
         @(negedge clk);
         bus_ack   = hit && (k == nb);
         bus_rdata = bus_ack ? rdata : $urandom;
         #1;
         check_eq("busy_stall", 32'(stall), 32'd1);
         check_eq("busy_req", 32'(bus_req), 32'd1);
         check_eq("busy_we", 32'(bus_we), 32'(wr));
         check_eq("busy_addr", bus_addr, addr);
         check_eq("busy_wdata", bus_wdata, wdata);
      end
      if (!wr) m_rd = hit ? rdata : 32'hDEADBEEF;
      if (!hit) m_err[1] = 1'b1;
      @(negedge clk);
      bus_ack   = 1'b0;
      bus_rdata = $urandom;
      #1;
      check_eq("done_stall", 32'(stall), 32'd0);
      check_eq("done_req", 32'(bus_req), 32'd0);
      check_eq("done_rd", readdata, m_rd);
      check_eq("done_err", 32'(err), 32'(m_err));
   endtask

   initial begin
      int n0;
      int r;
      int sel;
      logic [31:0] a;
      reset     = 1'b1;
      memread   = 1'b0;
      memwrite  = 1'b0;
      aluout    = '0;
      writedata = '0;
      bus_ack   = 1'b0;
      bus_rdata = '0;
      err_clr   = 1'b0;
      m_rd      = 32'd0;
      m_err     = 2'b00;
      #2;
      check_eq("rst_rd", readdata, 32'd0);
      check_eq("rst_req", 32'(bus_req), 32'd0);
      check_eq("rst_we", 32'(bus_we), 32'd0);
      check_eq("rst_addr", bus_addr, 32'd0);
      check_eq("rst_wdata", bus_wdata, 32'd0);
      check_eq("rst_err", 32'(err), 32'd0);
      check_eq("rst_stall", 32'(stall), 32'd0);
      @(negedge clk);
      reset = 1'b0;
      idle_cyc(1'b1, 1'b0);

      acc(1'b1, 1'b0, 32'h0000_0010, 32'h0, 32'h1234_5678, 2);
      idle_cyc(1'b0, 1'b0);
      acc(1'b0, 1'b1, 32'h0000_0020, 32'hCAFE_F00D, 32'h5555_5555, 0);
      idle_cyc(1'b0, 1'b0);

      mis_acc(1'b0, 32'h0000_0013, 1'b0);
      idle_cyc(1'b0, 1'b1);
      idle_cyc(1'b0, 1'b0);

      acc(1'b1, 1'b0, 32'h0000_0050, 32'h0, 32'h0, TO);
      idle_cyc(1'b0, 1'b1);
      idle_cyc(1'b0, 1'b0);

      // reset during the second BUSY cycle
      @(negedge clk);
      memread  = 1'b1;
      memwrite = 1'b0;
      aluout   = 32'h0000_0040;
      bus_ack  = 1'b0;
      @(negedge clk);
      @(negedge clk);
      #1;
      check_eq("pre_rst_req", 32'(bus_req), 32'd1);
      #2;
      reset = 1'b1;
      #1;
      check_eq("mid_rst_req", 32'(bus_req), 32'd0);
      check_eq("mid_rst_stall", 32'(stall), 32'd0);
      @(negedge clk);
      memread = 1'b0;
      @(negedge clk);
      reset = 1'b0;
      m_rd  = 32'd0;
      m_err = 2'b00;
      idle_cyc(1'b1, 1'b0);
      idle_cyc(1'b1, 1'b0);
      acc(1'b1, 1'b0, 32'h0000_0044, 32'h0, 32'hA5A5_0001, 1);

      // back-to-back loads, memread held across DONE
      n0 = n_req;
      acc(1'b1, 1'b0, 32'h0000_0100, 32'h0, 32'h0BAD_F00D, 1);
      acc(1'b1, 1'b0, 32'h0000_0104, 32'h0, 32'h1357_9BDF, 0);
      idle_cyc(1'b1, 1'b0);
      check_eq("b2b_txn", 32'(n_req - n0), 32'd2);

      // both strobes set behaves as a store
      acc(1'b1, 1'b1, 32'h0000_0200, 32'h7777_0000, 32'hFFFF_FFFF, 0);
      idle_cyc(1'b0, 1'b0);

      for (int i = 0; i < 80; i++) begin
         r = $urandom_range(0, 9);
         a = $urandom & 32'hFFFF_FFFC;
         if (r < 2) begin
            idle_cyc(1'($urandom_range(0, 1)),
                     ($urandom_range(0, 3) == 0));
         end else if (r == 2) begin
            mis_acc(1'($urandom_range(0, 1)),
                    a | 32'($urandom_range(1, 3)),
                    ($urandom_range(0, 3) == 0));
         end else begin
            sel = $urandom_range(0, 2);
            acc(sel != 1, sel != 0, a, $urandom, $urandom,
                $urandom_range(0, TO + 2));
         end
      end
      idle_cyc(1'b0, 1'b0);

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_err);
      $finish;
   end

endmodule
